// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: FETCH/DECODE/EXEC/MEM/WB sequencer for the RV32I-subset datapath.
// Outputs are decoded from state and instr; illegal opcodes and ack timeouts trap until reset.
module multicycle_ctrl #(
    parameter int ACK_TIMEOUT = 255,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      instr,
    input  logic             imem_ack,
    input  logic             dmem_ack,
    input  logic             alu_zero,
    output logic             imem_req,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             ir_we,
    output logic             pc_we,
    output logic             pc_src,
    output logic             reg_write,
    output logic [1:0]       wb_sel,
    output logic             alu_src,
    output logic [3:0]       alu_sel,
    output logic [2:0]       imm_sel,
    output logic             halted,
    output logic [1:0]       fault,
    output logic [CNT_W-1:0] instret
);
    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, TRAP} state_t;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_LUI = 7'b0110111;

    localparam logic [3:0] ALU_ADD    = 4'd0;
    localparam logic [3:0] ALU_SUB    = 4'd1;
    localparam logic [3:0] ALU_AND    = 4'd2;
    localparam logic [3:0] ALU_OR     = 4'd3;
    localparam logic [3:0] ALU_XOR    = 4'd4;
    localparam logic [3:0] ALU_SLL    = 4'd5;
    localparam logic [3:0] ALU_SRL    = 4'd6;
    localparam logic [3:0] ALU_SRA    = 4'd7;
    localparam logic [3:0] ALU_SLT    = 4'd8;
    localparam logic [3:0] ALU_SLTU   = 4'd9;
    localparam logic [3:0] ALU_PASS_B = 4'd10;

    localparam logic [7:0] TIMEOUT_LAST = 8'(ACK_TIMEOUT - 1);

    state_t     state;
    logic [7:0] wait_cnt;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       alt;
    logic       rd_nz;
    logic       is_r, is_i, is_lw, is_sw, is_br, is_jal, is_lui, legal;
    logic [3:0] alu_op;
    logic [3:0] alu_dec;
    logic       alu_src_dec;
    logic [2:0] imm_dec;
    logic       s_fetch, s_exec, s_mem, s_wb, ctl_on;
    logic       timed_out;
    logic       unused_instr;

    assign opcode       = instr[6:0];
    assign funct3       = instr[14:12];
    assign alt          = instr[30];
    assign rd_nz        = instr[11:7] != 5'd0;
    assign unused_instr = ^{instr[31], instr[29:15]};

    assign is_r   = opcode == OP_R;
    assign is_i   = opcode == OP_I;
    assign is_lw  = opcode == OP_LW;
    assign is_sw  = opcode == OP_SW;
    assign is_br  = opcode == OP_BR && funct3[2:1] == 2'b00;
    assign is_jal = opcode == OP_JAL;
    assign is_lui = opcode == OP_LUI;
    assign legal  = is_r | is_i | is_lw | is_sw | is_br | is_jal | is_lui;

    // funct7[5] only turns ADD into SUB for register-register ops; SRA/SRAI both honour it
    always_comb begin
        alu_op = ALU_ADD;
        case (funct3)
            3'b000:  alu_op = (is_r && alt) ? ALU_SUB : ALU_ADD;
            3'b001:  alu_op = ALU_SLL;
            3'b010:  alu_op = ALU_SLT;
            3'b011:  alu_op = ALU_SLTU;
            3'b100:  alu_op = ALU_XOR;
            3'b101:  alu_op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  alu_op = ALU_OR;
            default: alu_op = ALU_AND;
        endcase
    end

    assign alu_dec     = (is_r | is_i) ? alu_op : is_br ? ALU_SUB : is_lui ? ALU_PASS_B : ALU_ADD;
    assign alu_src_dec = is_i | is_lw | is_sw | is_lui;
    assign imm_dec     = is_sw ? 3'b001 : is_br ? 3'b010 : is_lui ? 3'b011 : is_jal ? 3'b100 : 3'b000;

    assign s_fetch   = state == FETCH;
    assign s_exec    = state == EXEC;
    assign s_mem     = state == MEM;
    assign s_wb      = state == WB;
    assign ctl_on    = s_exec | s_mem | s_wb;
    assign timed_out = wait_cnt == TIMEOUT_LAST;

    assign imem_req  = s_fetch;
    assign ir_we     = s_fetch & imem_ack;
    assign dmem_req  = s_mem;
    assign dmem_we   = s_mem & is_sw;
    assign alu_sel   = ctl_on ? alu_dec : 4'd0;
    assign alu_src   = ctl_on & alu_src_dec;
    assign imm_sel   = ctl_on ? imm_dec : 3'd0;
    assign pc_we     = (s_exec & (is_br | is_jal)) | (s_mem & dmem_ack & is_sw) | s_wb;
    assign pc_src    = s_exec & (is_jal | (is_br & (funct3[0] ^ alu_zero)));
    assign reg_write = rd_nz & ((s_exec & is_jal) | s_wb);
    assign wb_sel    = (s_exec & is_jal) ? 2'b10 : (s_wb & is_lw) ? 2'b01 : 2'b00;
    assign halted    = state == TRAP;

    // wait_cnt defaults to zero so every state entry starts a fresh ack window
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= FETCH;
            wait_cnt <= 8'd0;
            instret  <= '0;
            fault    <= 2'b00;
        end else begin
            wait_cnt <= 8'd0;
            case (state)
                FETCH: begin
                    if (imem_ack) begin
                        state <= DECODE;
                    end else if (timed_out) begin
                        state <= TRAP;
                        fault <= 2'b10;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                DECODE: begin
                    state <= legal ? EXEC : TRAP;
                    fault <= legal ? fault : 2'b01;
                end
                EXEC: begin
                    if (is_br | is_jal) begin
                        state   <= FETCH;
                        instret <= instret + 1'b1;
                    end else begin
                        state <= (is_lw | is_sw) ? MEM : WB;
                    end
                end
                MEM: begin
                    if (dmem_ack) begin
                        state   <= is_sw ? FETCH : WB;
                        instret <= is_sw ? instret + 1'b1 : instret;
                    end else if (timed_out) begin
                        state <= TRAP;
                        fault <= 2'b11;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                WB: begin
                    state   <= FETCH;
                    instret <= instret + 1'b1;
                end
                TRAP: state <= TRAP;
                default: state <= TRAP;
            endcase
        end
    end
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed and random instruction streams, each checked cycle by cycle
// against an instruction-level model of what the controller must drive.
module tb_multicycle_ctrl;
    localparam int TO = 4;
    localparam int CW = 4;
    localparam int K_R = 0, K_I = 1, K_LW = 2, K_SW = 3, K_BR = 4, K_JAL = 5, K_LUI = 6;
    localparam logic [3:0] F3_OP [8] = '{4'd0, 4'd5, 4'd8, 4'd9, 4'd4, 4'd6, 4'd3, 4'd2};

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          imem_ack = 1'b0;
    logic          dmem_ack = 1'b0;
    logic          alu_zero = 1'b0;
    logic [31:0]   instr = 32'd0;
    logic          imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_src, reg_write, alu_src, halted;
    logic [1:0]    wb_sel, fault;
    logic [3:0]    alu_sel;
    logic [2:0]    imm_sel;
    logic [CW-1:0] instret;
    logic [19:0]   obs;
    int            vectors = 0;
    int            miscompares = 0;
    int            exp_cnt = 0;
    bit            trapped = 1'b0;

    always #5 clk = ~clk;

    multicycle_ctrl #(.ACK_TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .instr(instr), .imem_ack(imem_ack), .dmem_ack(dmem_ack),
        .alu_zero(alu_zero), .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src), .reg_write(reg_write), .wb_sel(wb_sel),
        .alu_src(alu_src), .alu_sel(alu_sel), .imm_sel(imm_sel), .halted(halted),
        .fault(fault), .instret(instret)
    );

    assign obs = {imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_src, reg_write, wb_sel,
                  alu_src, alu_sel, imm_sel, halted, fault};

    function automatic logic [19:0] vec(input logic ireq, dreq, dwe, irwe, pcwe, psrc, rw,
                                        input logic [1:0] wb, input logic [7:0] ctl,
                                        input logic h, input logic [1:0] f);
        return {ireq, dreq, dwe, irwe, pcwe, psrc, rw, wb, ctl, h, f};
    endfunction

    function automatic int kind_of(input logic [31:0] iw);
        case (iw[6:0])
            7'b0110011: return K_R;
            7'b0010011: return K_I;
            7'b0000011: return K_LW;
            7'b0100011: return K_SW;
            7'b1100011: return (iw[14:13] == 2'b00) ? K_BR : -1;
            7'b1101111: return K_JAL;
            7'b0110111: return K_LUI;
            default:    return -1;
        endcase
    endfunction

    // {alu_src, alu_sel, imm_sel} the instruction's meaning calls for
    function automatic logic [7:0] ref_ctl(input logic [31:0] iw);
        logic [3:0] op;
        int f3;
        int k;
        f3 = int'(iw[14:12]);
        k = kind_of(iw);
        op = F3_OP[f3];
        if (iw[30] && f3 == 0 && k == K_R) op = 4'd1;
        if (iw[30] && f3 == 5) op = 4'd7;
        case (k)
            K_R:     return {1'b0, op, 3'd0};
            K_I:     return {1'b1, op, 3'd0};
            K_LW:    return {1'b1, 4'd0, 3'd0};
            K_SW:    return {1'b1, 4'd0, 3'd1};
            K_BR:    return {1'b0, 4'd1, 3'd2};
            K_JAL:   return {1'b0, 4'd0, 3'd4};
            K_LUI:   return {1'b1, 4'd10, 3'd3};
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        logic [2:0] f3;
        logic [6:0] op;
        r = $urandom;
        f3 = r[14:12];
        case ($urandom_range(0, 7))
            0: return {1'b0, (f3 == 3'd0 || f3 == 3'd5) ? r[30] : 1'b0, 5'b0, r[24:15], f3, r[11:7], 7'b0110011};
            1: return {r[31:7], 7'b0010011};
            2: return {r[31:15], 3'b010, r[11:7], 7'b0000011};
            3: return {r[31:15], 3'b010, r[11:7], 7'b0100011};
            4: return {r[31:15], 2'b00, r[12], r[11:7], 7'b1100011};
            5: return {r[31:7], 7'b1101111};
            6: return {r[31:7], 7'b0110111};
            default: begin
                if (r[0]) return {r[31:15], 3'($urandom_range(2, 7)), r[11:7], 7'b1100011};
                op = 7'($urandom);
                while (kind_of({25'd0, op}) >= 0) op = 7'($urandom);
                return {r[31:7], op};
            end
        endcase
    endfunction

    task automatic check(input string tag, input logic [19:0] e);
        vectors++;
        assert (obs === e) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, e);
        end
    endtask

    task automatic check_cnt(input string tag);
        logic [CW-1:0] e;
        e = exp_cnt[CW-1:0];
        vectors++;
        assert (instret === e) else begin
            miscompares++;
            $error("FAIL %s instret: observed %0d expected %0d", tag, instret, e);
        end
    endtask

    task automatic drive(input logic ia, input logic da, input logic z);
        imem_ack = ia;
        dmem_ack = da;
        alu_zero = z;
        #1;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        alu_zero = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        exp_cnt = 0;
        trapped = 1'b0;
        check("reset", vec(1, 0, 0, 0, 0, 0, 0, 2'b00, 8'h00, 0, 2'b00));
        check_cnt("reset");
    endtask

    task automatic retire(input string nm);
        exp_cnt = (exp_cnt + 1) % (1 << CW);
        check_cnt(nm);
    endtask

    // acks held high in TRAP must not wake the controller
    task automatic trap_chk(input string nm, input logic [1:0] f);
        for (int i = 0; i < 2; i++) begin
            drive(1, 1, 1);
            check({nm, " trap"}, vec(0, 0, 0, 0, 0, 0, 0, 2'b00, 8'h00, 1, f));
            tick();
        end
        trapped = 1'b1;
    endtask

    task automatic run(input logic [31:0] iw, input int id, input int dd, input logic z, input string nm);
        int k;
        logic [7:0] c;
        logic rw, tk, ack;
        k = kind_of(iw);
        c = ref_ctl(iw);
        rw = iw[11:7] != 5'd0;
        tk = iw[12] ? !z : z;
        instr = iw;
        for (int i = 0; i < TO && i <= id; i++) begin
            ack = i == id;
            drive(ack, 0, z);
            check({nm, " fetch"}, vec(1, 0, 0, ack, 0, 0, 0, 2'b00, 8'h00, 0, 2'b00));
            tick();
        end
        if (id >= TO) begin trap_chk(nm, 2'b10); return; end
        drive(0, 0, z);
        check({nm, " decode"}, vec(0, 0, 0, 0, 0, 0, 0, 2'b00, 8'h00, 0, 2'b00));
        tick();
        if (k < 0) begin trap_chk(nm, 2'b01); return; end
        drive(0, 0, z);
        if (k == K_BR || k == K_JAL) begin
            check({nm, " exec"}, (k == K_BR) ? vec(0, 0, 0, 0, 1, tk, 0, 2'b00, c, 0, 2'b00)
                                             : vec(0, 0, 0, 0, 1, 1, rw, 2'b10, c, 0, 2'b00));
            tick();
            retire(nm);
            return;
        end
        check({nm, " exec"}, vec(0, 0, 0, 0, 0, 0, 0, 2'b00, c, 0, 2'b00));
        tick();
        if (k == K_LW || k == K_SW) begin
            for (int i = 0; i < TO && i <= dd; i++) begin
                ack = i == dd;
                drive(0, ack, z);
                check({nm, " mem"}, vec(0, 1, k == K_SW, 0, k == K_SW && ack, 0, 0, 2'b00, c, 0, 2'b00));
                tick();
            end
            if (dd >= TO) begin trap_chk(nm, 2'b11); return; end
            if (k == K_SW) begin retire(nm); return; end
        end
        drive(0, 0, z);
        check({nm, " wb"}, vec(0, 0, 0, 0, 1, 0, rw, (k == K_LW) ? 2'b01 : 2'b00, c, 0, 2'b00));
        tick();
        retire(nm);
    endtask

    initial begin
        do_reset();
        run(32'h002081B3, 0, 0, 0, "add");
        run(32'h0000A283, 0, 2, 0, "lw");
        run(32'h0020A223, 1, 1, 0, "sw");
        run(32'h00000463, 0, 0, 1, "beq_taken");
        run(32'h00000463, 0, 0, 0, "beq_not");
        run(32'h00001463, 2, 0, 0, "bne_taken");
        run(32'h00208033, 0, 0, 0, "add_rd0");
        run(32'h4050D193, 0, 0, 0, "srai");
        run(32'h123452B7, 3, 0, 0, "lui");
        run(32'h008000EF, 0, 0, 0, "jal");
        run(32'h00000000, 0, 0, 0, "illegal");
        do_reset();
        run(32'h002081B3, TO, 0, 0, "imem_timeout");
        do_reset();
        run(32'h0000A283, 0, TO, 0, "dmem_timeout");
        do_reset();
        run(32'h002081B3, 0, 0, 0, "pre_rst");
        instr = 32'h0000A283;
        drive(1, 0, 0);
        tick();
        drive(0, 0, 0);
        tick();
        tick();
        rst = 1'b1;
        drive(0, 1, 0);
        check("rst_mem", vec(0, 1, 0, 0, 0, 0, 0, 2'b00, 8'h80, 0, 2'b00));
        tick();
        rst = 1'b0;
        drive(0, 0, 0);
        exp_cnt = 0;
        check("after_rst_mem", vec(1, 0, 0, 0, 0, 0, 0, 2'b00, 8'h00, 0, 2'b00));
        check_cnt("after_rst_mem");
        for (int n = 0; n < 300; n++) begin
            run(rand_instr(), ($urandom_range(0, 19) == 0) ? TO : $urandom_range(0, TO - 1),
                ($urandom_range(0, 19) == 0) ? TO : $urandom_range(0, TO - 1),
                1'($urandom), "rand");
            if (trapped) do_reset();
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle sequencing controller for the RV32I-subset core datapath: PC, register file, ALU, immediate generator, ALU/writeback/PC muxes.
- Steps each instruction through FETCH, DECODE, EXEC, MEM and WB states.
- Drives every mux select and write enable; handshakes with instruction and data memories.
- Traps to a halted state on illegal opcodes or memory-ack timeout.

Parameters:
- ACK_TIMEOUT, 255: max cycles to wait for imem_ack/dmem_ack before a timeout trap; valid range 1..255.
- CNT_W, 32: width of the retired-instruction counter.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- instr  input  32  instruction register contents (valid from DECODE onward).
- imem_ack  input  1  instruction memory ack; data is valid in the same cycle.
- dmem_ack  input  1  data memory ack; load data is valid in the same cycle.
- alu_zero  input  1  ALU zero flag.
- imem_req  output  1  fetch request.
- dmem_req  output  1  data access request.
- dmem_we  output  1  data write (store).
- ir_we  output  1  instruction register load.
- pc_we  output  1  PC update.
- pc_src  output  1  0 = PC+4, 1 = PC+imm (branch adder).
- reg_write  output  1  register file write enable.
- wb_sel  output  2  00 = ALU, 01 = dmem, 10 = PC+4.
- alu_src  output  1  0 = regout2, 1 = immediate.
- alu_sel  output  4  ALU operation (encoding below).
- imm_sel  output  3  000 I, 001 S, 010 B, 011 U, 100 J.
- halted  output  1  trap state indicator.
- fault  output  2  00 none, 01 illegal opcode, 10 imem timeout, 11 dmem timeout.
- instret  output  CNT_W  retired-instruction count.

Behaviour:
- Reset: state = FETCH, wait counter = 0, instret = 0, fault = 00.
- Outputs are Moore/decoded combinationally from state and instr.
- All enables and requests are 0 except in the cases listed below. Under rst, every output is 0 in the following cycle except imem_req = 1 (FETCH).
- alu_sel encoding: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLL, 0110 SRL, 0111 SRA, 1000 SLT, 1001 SLTU, 1010 PASS_B.
- Supported opcodes:
  - 0110011 R-type (funct7[5] selects SUB/SRA)
  - 0010011 I-ALU (funct7[5] honoured only for SRAI)
  - 0000011 LW
  - 0100011 SW
  - 1100011 BEQ/BNE (funct3 000/001)
  - 1101111 JAL
  - 0110111 LUI (PASS_B, U-imm)
- Any other opcode, or a BRANCH funct3 other than 000/001, is illegal.
- FETCH:
  - imem_req = 1.
  - On imem_ack: ir_we = 1 for that cycle, go to DECODE.
  - Wait counter increments each non-ack cycle; reaching ACK_TIMEOUT goes to TRAP with fault = 10.
- DECODE: 1 cycle. Illegal instruction goes to TRAP with fault = 01; otherwise go to EXEC.
- EXEC (imm_sel, alu_src, alu_sel decoded):
  - R/I/LUI: go to WB.
  - LW/SW: ADD with imm (I/S), go to MEM.
  - BEQ/BNE:
    - SUB; pc_we = 1.
    - pc_src = 1 iff (BEQ and alu_zero) or (BNE and !alu_zero).
    - instret++, go to FETCH.
  - JAL:
    - reg_write = 1 (if rd != 0), wb_sel = 10.
    - pc_we = 1, pc_src = 1, imm_sel = 100.
    - instret++, go to FETCH.
- MEM:
  - dmem_req = 1; dmem_we = 1 for SW. ALU controls are held stable.
  - On dmem_ack, SW: pc_we = 1, pc_src = 0, instret++, go to FETCH.
  - On dmem_ack, LW: go to WB.
  - Timeout as in FETCH, with fault = 11.
- WB:
  - reg_write = 1 unless rd == 0; wb_sel = 01 for LW, 00 otherwise.
  - pc_we = 1, pc_src = 0, instret++, go to FETCH.
- Wait counter clears on every state entry.
- instret wraps modulo 2^CNT_W.
- TRAP: halted = 1, all enables/requests 0, fault held. Exit only via rst.
- rst has priority over ack in the same cycle. A reset mid-MEM drops dmem_req in the next cycle, with no reg_write or pc_we.

Test Plan:
- rst, then instr = 0x002081B3 (add x3,x1,x2), ack on 1st FETCH cycle -> states FETCH, DECODE, EXEC, WB; WB cycle has reg_write = 1, wb_sel = 00, alu_sel = 0000, alu_src = 0, pc_we = 1, pc_src = 0; instret = 1; total 4 cycles.
- instr = 0x0000A283 (lw x5,0(x1)), dmem_ack after 3 cycles -> dmem_req high for 3 cycles, dmem_we = 0; then WB with reg_write = 1, wb_sel = 01; instret increments.
- instr = 0x0020A223 (sw x2,4(x1)) -> MEM with dmem_we = 1, imm_sel = 001; on ack pc_we = 1, reg_write never asserted.
- instr = 0x00000463 (beq x0,x0,8) with alu_zero = 1 -> EXEC pc_we = 1, pc_src = 1; repeat with alu_zero = 0 -> pc_src = 0.
- instr = 0x00000000 -> TRAP after DECODE, halted = 1, fault = 01; imem_ack held low with ACK_TIMEOUT = 4 -> TRAP with fault = 10 after 4 FETCH cycles.
- rst asserted during MEM of LW with dmem_ack = 1 in the same cycle -> next cycle FETCH, instret = 0, reg_write = 0; instr with rd = 0 (0x00208033) -> reg_write stays 0 in WB.
